// File: rtl/full_adder.sv
// One-bit full adder: the ripple-chain cell of full_adder_four.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_four.sv
// 4-bit unsigned ripple-carry adder built from four full_adder cells,
// with an optional output register (REGISTERED=1) or a purely combinational path.
module full_adder_four #(
    parameter int unsigned REGISTERED = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_a3,
    input  logic in_a2,
    input  logic in_a1,
    input  logic in_a0,
    input  logic in_b3,
    input  logic in_b2,
    input  logic in_b1,
    input  logic in_b0,
    output logic out_s3,
    output logic out_s2,
    output logic out_s1,
    output logic out_s0,
    output logic out_s4
);

    localparam int unsigned WIDTH = 4;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   result;

    assign op_a     = {in_a3, in_a2, in_a1, in_a0};
    assign op_b     = {in_b3, in_b2, in_b1, in_b0};
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (op_a[i]),
            .b    (op_b[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    if (REGISTERED != 0) begin : g_reg
        logic [WIDTH:0] result_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                result_q <= '0;
            end else begin
                result_q <= {carry[WIDTH], sum_bits};
            end
        end

        assign result = result_q;
    end else begin : g_comb
        // Clock and reset are intentionally ignored in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign result         = {carry[WIDTH], sum_bits};
    end

    assign out_s4 = result[4];
    assign out_s3 = result[3];
    assign out_s2 = result[2];
    assign out_s1 = result[1];
    assign out_s0 = result[0];

endmodule

// File: tb/tb_full_adder_four.sv
// Bench for full_adder_four: registered and combinational builds side by side,
// checked against an arithmetic A+B model with a one-cycle pipeline for the registered build.
module tb_full_adder_four;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [4:0] sum_r;
    logic [4:0] sum_c;
    logic [4:0] model_q = '0;
    logic       cmp_en = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    full_adder_four #(.REGISTERED(1)) dut_r (
        .clk(clk), .rst_n(rst_n),
        .in_a3(a[3]), .in_a2(a[2]), .in_a1(a[1]), .in_a0(a[0]),
        .in_b3(b[3]), .in_b2(b[2]), .in_b1(b[1]), .in_b0(b[0]),
        .out_s3(sum_r[3]), .out_s2(sum_r[2]), .out_s1(sum_r[1]), .out_s0(sum_r[0]),
        .out_s4(sum_r[4])
    );

    full_adder_four #(.REGISTERED(0)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_a3(a[3]), .in_a2(a[2]), .in_a1(a[1]), .in_a0(a[0]),
        .in_b3(b[3]), .in_b2(b[2]), .in_b1(b[1]), .in_b0(b[0]),
        .out_s3(sum_c[3]), .out_s2(sum_c[2]), .out_s1(sum_c[1]), .out_s0(sum_c[0]),
        .out_s4(sum_c[4])
    );

    // Model: registered result is last edge's A+B, cleared while reset is low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_q <= '0;
        else        model_q <= 5'(a) + 5'(b);
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b (%0d) want %b (%0d) a=%0d b=%0d",
                     name, act, act, exp, exp, a, b);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("reg_vs_model", sum_r, model_q);
            chk("comb_vs_model", sum_c, 5'(a) + 5'(b));
        end
    end

    task automatic apply(input logic [3:0] na, input logic [3:0] nb);
        @(posedge clk);
        #1;
        a = na;
        b = nb;
    endtask

    // Directed case with a hand-computed literal; also pins the model itself.
    task automatic directed(input string name, input logic [3:0] na, input logic [3:0] nb,
                            input logic [4:0] lit);
        apply(na, nb);
        #1;
        chk({name, "_comb"}, sum_c, lit);
        @(posedge clk);
        #1;
        chk({name, "_reg"}, sum_r, lit);
        chk({name, "_model"}, model_q, lit);
    endtask

    initial begin
        #3;
        chk("reset_reg", sum_r, 5'd0);
        chk("reset_model", model_q, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_after_reset", sum_r, 5'd0);
        cmp_en = 1'b1;

        directed("zero", 4'd0, 4'd0, 5'b00000);
        directed("max", 4'd15, 4'd15, 5'b11110);
        directed("carry_boundary", 4'd8, 4'd8, 5'b10000);
        directed("no_carry", 4'd5, 4'd10, 5'b01111);
        directed("just_overflow", 4'd1, 4'd15, 5'b10000);

        for (int unsigned i = 0; i < 256; i++) begin
            apply(4'(i >> 4), 4'(i));
        end

        for (int unsigned i = 0; i < 300; i++) begin
            apply(4'($urandom_range(15)), 4'($urandom_range(15)));
        end

        // Mid-cycle asynchronous reset with a pending result.
        apply(4'd7, 4'd9);
        @(posedge clk);
        #2;
        chk("pre_reset_reg", sum_r, 5'b10000);
        rst_n = 1'b0;
        #1;
        chk("async_reset_reg", sum_r, 5'd0);
        chk("async_reset_comb", sum_c, 5'b10000);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("held_after_release", sum_r, 5'd0);
        @(posedge clk);
        #1;
        chk("post_reset_edge", sum_r, 5'b10000);

        for (int unsigned i = 0; i < 50; i++) begin
            apply(4'($urandom_range(15)), 4'($urandom_range(15)));
        end
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
